// File: rtl/lc3b_types.sv
// lc3b_types: LC-3b word/cacheline types plus the pmem_responder FSM encoding and latency helper
package lc3b_types;
   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_cacheline;
   localparam int PMEM_LAT_W = 8;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;
   function automatic logic [PMEM_LAT_W-1:0] pmem_lat_init(input int lat);
      return (lat < 2) ? '0 : PMEM_LAT_W'(lat - 1);
   endfunction
endpackage

// File: rtl/pmem_array.sv
// pmem_array: 2^INDEX_BITS x 128 line store, synchronous write and synchronous read capture on one index
module pmem_array
   import lc3b_types::*;
#(
   parameter int INDEX_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [INDEX_BITS-1:0] idx_i,
   input  lc3b_cacheline         wdata_i,
   output lc3b_cacheline         rdata_o
);
   lc3b_cacheline mem_q [2**INDEX_BITS];
   lc3b_cacheline rdata_q;
   // line storage is never cleared, so contents before the first write are undefined
   always_ff @(posedge clk)
      if (we_i) mem_q[idx_i] <= wdata_i;
   // read data register: loads only on a read capture and holds otherwise
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[idx_i];
   assign rdata_o = rdata_q;
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency cacheline memory responder; PMEM_PROTO_CHECK_EN enables the requester protocol checker
module pmem_responder
   import lc3b_types::*;
#(
   parameter int READ_LATENCY  = 10,
   parameter int WRITE_LATENCY = 10,
   parameter int INDEX_BITS    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pmem_read,
   input  logic          pmem_write,
   input  lc3b_word      pmem_address,
   input  lc3b_cacheline pmem_wdata,
   output logic          pmem_resp,
   output lc3b_cacheline pmem_rdata,
   output logic          proto_err
);
   localparam logic [PMEM_LAT_W-1:0] RD_INIT = pmem_lat_init(READ_LATENCY);
   localparam logic [PMEM_LAT_W-1:0] WR_INIT = pmem_lat_init(WRITE_LATENCY);
   pmem_state_t state_q, state_d;
   logic [PMEM_LAT_W-1:0] cnt_q, cnt_d;
   logic accept;
   logic unused_addr;
   // no acceptance while reset is held, so nothing is written into the array during reset
   assign accept      = rst_n && state_q == IDLE && (pmem_read || pmem_write);
   assign unused_addr = ^pmem_address;
   assign pmem_resp   = state_q == RESP;
   pmem_array #(.INDEX_BITS(INDEX_BITS)) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (accept && pmem_write && !pmem_read),
      .re_i    (accept && pmem_read),
      .idx_i   (pmem_address[INDEX_BITS+3:4]),
      .wdata_i (pmem_wdata),
      .rdata_o (pmem_rdata)
   );
   // next state: load LATENCY-1 on accept, count down in BUSY, respond when the count reaches 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         cnt_d   = pmem_read ? RD_INIT : WR_INIT;
         state_d = (cnt_d == '0) ? RESP : BUSY;
      end else if (state_q == BUSY) begin
         cnt_d   = (cnt_q != '0) ? cnt_q - PMEM_LAT_W'(1) : cnt_q;
         state_d = (cnt_q <= PMEM_LAT_W'(1)) ? RESP : BUSY;
      end else if (state_q == RESP) begin
         state_d = IDLE;
      end
   end
   // state and counter registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
`ifdef PMEM_PROTO_CHECK_EN
   logic          op_rd_q;
   lc3b_word      addr_q;
   lc3b_cacheline wdata_q;
   logic          err_q, err_d, busy_bad;
   assign busy_bad = (op_rd_q ? !(pmem_read && !pmem_write) : !(pmem_write && !pmem_read))
                   || pmem_address != addr_q || (!op_rd_q && pmem_wdata != wdata_q);
   // sticky violation: both ops in IDLE, or request not held stable while BUSY
   always_comb err_d = err_q || (accept && pmem_read && pmem_write) || (state_q == BUSY && busy_bad);
   // captured request used as the stability reference during BUSY
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op_rd_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= err_d;
         if (accept) begin
            op_rd_q <= pmem_read;
            addr_q  <= pmem_address;
            wdata_q <= pmem_wdata;
         end
      end
   assign proto_err = err_q;
`else
   assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: transaction-level model check of two responder configurations (10/10 and 1/3 latency)
module tb_pmem_responder;
`ifdef PMEM_PROTO_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam logic [127:0] LD  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] LD2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] LA  = 128'hA5A5_A5A5_0101_0101_1234_5678_9ABC_DEF0;
   localparam logic [127:0] LB  = 128'h5A5A_5A5A_F0F0_F0F0_0FED_CBA9_8765_4321;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rd [2];
   logic wr [2];
   logic resp [2];
   logic perr [2];
   logic [15:0]  ad [2];
   logic [127:0] wd [2];
   logic [127:0] rdat [2];
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int rlat [2] = '{10, 1};
   int wlat [2] = '{10, 3};
   int resp_at [2];
   int pend_at [2];
   int perr_at [2];
   bit pend [2];
   bit known [2];
   bit pend_known [2];
   logic [127:0] exp_rd [2];
   logic [127:0] pend_rd [2];
   logic [127:0] mem [2][256];
   bit valid [2][256];
   int last_e0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pmem_responder #(.READ_LATENCY(10), .WRITE_LATENCY(10), .INDEX_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_address(ad[0]),
      .pmem_wdata(wd[0]), .pmem_resp(resp[0]), .pmem_rdata(rdat[0]), .proto_err(perr[0]));
   pmem_responder #(.READ_LATENCY(1), .WRITE_LATENCY(3), .INDEX_BITS(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_address(ad[1]),
      .pmem_wdata(wd[1]), .pmem_resp(resp[1]), .pmem_rdata(rdat[1]), .proto_err(perr[1]));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 2; i++) begin
         resp_at[i] = -100;
         pend[i]    = 1'b0;
         pend_at[i] = 1 << 30;
         perr_at[i] = 1 << 30;
         exp_rd[i]  = '0;
         known[i]   = 1'b1;
      end
   endtask

   task automatic cmp();
      logic [127:0] er;
      bit ek;
      for (int i = 0; i < 2; i++) begin
         er = (pend[i] && cyc >= pend_at[i]) ? pend_rd[i] : exp_rd[i];
         ek = (pend[i] && cyc >= pend_at[i]) ? pend_known[i] : known[i];
         check($sformatf("resp%0d@%0d", i, cyc), 128'(resp[i]), 128'(cyc == resp_at[i]));
         if (ek) check($sformatf("rdata%0d@%0d", i, cyc), rdat[i], er);
         check($sformatf("proto_err%0d@%0d", i, cyc), 128'(perr[i]), 128'(CHK && cyc >= perr_at[i]));
      end
   endtask

   task automatic step();
      @(negedge clk);
      cmp();
      #1;
   endtask

   task automatic go(input int id, input bit r, input bit w, input logic [15:0] a, input logic [127:0] d);
      int e0;
      int ix;
      rd[id] = r;
      wr[id] = w;
      ad[id] = a;
      wd[id] = d;
      e0 = (cyc + 1 > resp_at[id] + 2) ? cyc + 1 : resp_at[id] + 2;
      ix = (int'(a) / 16) % 256;
      if (pend[id]) begin
         exp_rd[id] = pend_rd[id];
         known[id]  = pend_known[id];
      end
      pend[id]    = r;
      pend_at[id] = e0;
      if (r) begin
         pend_rd[id]    = mem[id][ix];
         pend_known[id] = valid[id][ix];
      end else begin
         mem[id][ix]   = d;
         valid[id][ix] = 1'b1;
      end
      if (r && w && e0 < perr_at[id]) perr_at[id] = e0;
      resp_at[id] = e0 + (r ? rlat[id] : wlat[id]) - 1;
      last_e0 = e0;
   endtask

   task automatic wait_resp(input int id, output int at);
      at = -1;
      for (int n = 0; n < 300 && at < 0; n++) begin
         step();
         if (resp[id]) at = cyc;
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout%0d: got none expected resp by cycle %0d", id, resp_at[id]);
      end
   endtask

   initial begin
      int r1, r2, e;
      for (int i = 0; i < 2; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0;
      end
      clr();
      rd[0] = 1'b1;
      ad[0] = 16'h0200;
      repeat (3) step();
      check("rst_rdata", rdat[0], '0);
      check("rst_resp", 128'(resp[0]), '0);
      rst_n = 1'b1;
      go(0, 1'b1, 1'b0, 16'h0200, '0);
      e = last_e0;
      wait_resp(0, r1);
      check("first_rd_latency", 128'(r1 - e + 1), 128'(10));
      rd[0] = 1'b0;
      repeat (2) step();
      go(0, 1'b0, 1'b1, 16'h0040, LD);
      e = last_e0;
      wait_resp(0, r1);
      check("wr_latency", 128'(r1 - e + 1), 128'(10));
      go(0, 1'b1, 1'b0, 16'h004E, '0);
      wait_resp(0, r1);
      check("rd_after_wr", rdat[0], LD);
      rd[0] = 1'b0;
      step();
      go(0, 1'b0, 1'b1, 16'h1000, LD2);
      wait_resp(0, r1);
      go(0, 1'b1, 1'b0, 16'h0000, '0);
      wait_resp(0, r1);
      check("alias_rdata", rdat[0], LD2);
      check("alias_perr", 128'(perr[0]), '0);
      rd[0] = 1'b0;
      step();
      go(1, 1'b0, 1'b1, 16'h0000, LA);
      wait_resp(1, r1);
      go(1, 1'b0, 1'b1, 16'h0010, LB);
      wait_resp(1, r1);
      go(1, 1'b1, 1'b0, 16'h0000, '0);
      wait_resp(1, r1);
      check("b2b_first", rdat[1], LA);
      go(1, 1'b1, 1'b0, 16'h0010, '0);
      wait_resp(1, r2);
      check("b2b_spacing", 128'(r2 - r1), 128'(2));
      check("b2b_second", rdat[1], LB);
      rd[1] = 1'b0;
      step();
      check("b2b_resp_width", 128'(resp[1]), '0);
      go(0, 1'b1, 1'b0, 16'h0040, '0);
      repeat (3) step();
      ad[0] = 16'h0050;
      if (cyc + 1 < perr_at[0]) perr_at[0] = cyc + 1;
      wait_resp(0, r1);
      check("addr_change_rdata", rdat[0], LD);
      rd[0] = 1'b0;
      step();
      check("perr_sticky_a", 128'(perr[0]), 128'(CHK));
      go(0, 1'b1, 1'b1, 16'h0040, LB);
      wait_resp(0, r1);
      check("both_high_rdata", rdat[0], LD);
      rd[0] = 1'b0;
      wr[0] = 1'b0;
      repeat (3) step();
      check("perr_sticky_b", 128'(perr[0]), 128'(CHK));
      go(0, 1'b1, 1'b0, 16'h0040, '0);
      repeat (5) step();
      rst_n = 1'b0;
      rd[0] = 1'b0;
      clr();
      repeat (2) step();
      check("midrst_perr", 128'(perr[0]), '0);
      check("midrst_rdata", rdat[0], '0);
      rst_n = 1'b1;
      repeat (12) step();
      go(0, 1'b1, 1'b0, 16'h004E, '0);
      e = last_e0;
      wait_resp(0, r1);
      check("post_rst_latency", 128'(r1 - e + 1), 128'(10));
      check("post_rst_rdata", rdat[0], LD);
      rd[0] = 1'b0;
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pmem_responder.md
# pmem_responder

Line-granular physical-memory responder for the `pmem_*` cacheline interface driven by the arbiter. It accepts one read or write request at a time and holds it for a programmable latency. It then pulses `pmem_resp` for exactly one cycle, returning a 128-bit line on reads. It terminates the memory side of the CPU/L1/arbiter hierarchy in simulation and FPGA builds, and it checks requester protocol compliance.

## Interface
Parameters:
- `READ_LATENCY`, 10, cycles from request acceptance to `pmem_resp` for reads (legal range 1..255)
- `WRITE_LATENCY`, 10, same for writes (legal range 1..255)
- `INDEX_BITS`, 8, log2 of stored lines; address bits [INDEX_BITS+3:4] select the line, and higher bits alias

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `pmem_read` in 1: read request, level, held until resp
- `pmem_write` in 1: write request, level, held until resp
- `pmem_address` in 16 (`lc3b_word`): byte address; bits [3:0] ignored
- `pmem_wdata` in 128 (`lc3b_cacheline`): write line
- `pmem_resp` out 1: one-cycle completion pulse
- `pmem_rdata` out 128 (`lc3b_cacheline`): read line, valid while `pmem_resp`=1
- `proto_err` out 1: sticky protocol-violation flag

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: when `pmem_read` or `pmem_write` is high at an edge, the request is accepted. On acceptance:
  - capture the address, op and (for writes) wdata;
  - load the counter with LATENCY-1 for the selected op;
  - go to BUSY if LATENCY>1, else go to RESP.
- Writes commit to the array at the acceptance edge. Reads capture the array line into the rdata register at the acceptance edge. As a result, a read after a write to the same line returns the new data.
- If both `pmem_read` and `pmem_write` are high in IDLE, service the read only and set `proto_err`.
- BUSY: decrement the counter each edge; on the edge where the counter equals 0, go to RESP.
- RESP: `pmem_resp`=1 for this cycle only, then return to IDLE unconditionally.
- A request still high in the IDLE cycle after RESP is treated as a new request. Requesters drop the request combinationally on resp, per existing cache FSMs.
- Counter is 8 bits, unsigned, and never wraps. A LATENCY of 0 is clamped to 1.
- The array is not cleared by reset; line contents before the first write are undefined (X in sim).

## Timing
- Request first sampled high at edge E0. `pmem_resp` is high during the cycle after edge E0+LATENCY-1, so the requester sees the response at edge E0+LATENCY. No back-to-back resp is possible; the minimum request-to-request spacing is LATENCY+1 cycles.
- `pmem_rdata` is registered. It changes only at read acceptance and holds its value otherwise, including after RESP.
- Reset values: `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0, state=IDLE, counter=0.
- Reset asserted mid-operation: the transaction is abandoned and no resp is issued. A write accepted before reset has already been committed.

## Configuration
- `PMEM_PROTO_CHECK_EN` defined: `proto_err` sets and stays set until reset on any of these:
  - read and write both high in IDLE;
  - request dropped, or `pmem_address` changed, or op changed, while in BUSY;
  - `pmem_wdata` changed during a BUSY write.
- `PMEM_PROTO_CHECK_EN` undefined: the checking logic is removed and `proto_err` is tied 0. Functional behaviour is otherwise identical; dropped requests still complete and resp still pulses.

## Structure
- `lc3b_types` supplies `lc3b_word` and `lc3b_cacheline`.
- Add `pmem_state_t` (IDLE/BUSY/RESP) and `PMEM_LAT_W = 8` to `lc3b_types`.
- One sub-module, `pmem_array`: 2^INDEX_BITS x 128 storage with synchronous write and synchronous read-capture on a shared index.
- FSM, counter and checker stay in `pmem_responder`.

## Test plan
- Reset with `pmem_read` held high → `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0 until `rst_n` rises. First resp arrives exactly READ_LATENCY cycles after the first sampling edge.
- Write line 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to 0x0040 (WRITE_LATENCY=10), then read 0x004E → resp pulses after 10 cycles for each, and the read returns the same line.
- READ_LATENCY=1 with reads to 0x0000 and 0x0010 issued back-to-back → each resp is one cycle wide, and the second request is accepted in the IDLE cycle immediately after the first resp.
- INDEX_BITS=8: write 0x1000, read 0x0000 → aliased line returned; `proto_err` stays 0.
- With `PMEM_PROTO_CHECK_EN`: assert read and write together, or change address 0x0040→0x0050 during BUSY → `proto_err`=1 and sticky; the read completes with 0x0040 data.
- Assert `rst_n`=0 at cycle 5 of a 10-cycle read → no resp; after release, a new read completes normally.
